// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing store behind a valid/ready memory port.
// Define MEM_RESPONDER_ERROR_EN to reject out-of-range and instruction-write accesses.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           err_q, err_d;
  logic           ready_q, ready_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           commit;
  logic           req_err;
  logic           unused_in;

  logic [31:0]    mem_q [DEPTH];

  assign unused_in = ^{mem_addr, mem_instr};

`ifdef MEM_RESPONDER_ERROR_EN
  assign req_err = (|mem_addr[31:AW+2])
                 | (mem_instr & (|mem_wstrb));
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          idx_d   = mem_addr[AW+1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          err_d   = req_err;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes land on the edge entering RESP, using the request as it will be latched.
    commit = (state_d == RESP) && (state_q != RESP)
          && (wstrb_d != 4'b0) && !err_d && !reset;

    ready_d = (state_q == RESP);
    rdata_d = '0;
    if ((state_q == RESP) && (wstrb_q == 4'b0) && !err_q) begin
      rdata_d = mem_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_d[b]) begin
          mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

`ifdef MEM_RESPONDER_ERROR_EN
  logic error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_q == RESP) && err_q;
    end
  end

  assign mem_error = error_q;
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random traffic against an edge-timeline reference model,
// plus directed scenarios with literal expectations.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  logic        f_valid;
  logic [31:0] f_addr;
  logic [31:0] f_wdata;
  logic [3:0]  f_wstrb;
  logic        f_ready;
  logic [31:0] f_rdata;
  logic        f_error;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error)
  );

  mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_fast (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (f_valid),
    .mem_instr (1'b0),
    .mem_addr  (f_addr),
    .mem_wdata (f_wdata),
    .mem_wstrb (f_wstrb),
    .mem_ready (f_ready),
    .mem_rdata (f_rdata),
    .mem_error (f_error)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Reference model: one pending request described by the edges at which
  // it commits, responds, and frees the port.
  logic [31:0] ref_mem [int];
  bit          p_busy  = 0;
  int          p_commit, p_resp, p_idx;
  int          free_at  = 0;
  int          acc_edge = -1;
  logic [31:0] p_wd;
  logic [3:0]  p_ws;
  bit          p_err;
  bit          e_rdy, e_err, e_known;
  logic [31:0] e_rd;

  always @(posedge clk) begin
    logic [31:0] tmp;
    cyc++;
    e_rdy = 0; e_err = 0; e_rd = '0; e_known = 1;
    if (reset) begin
      p_busy  = 0;
      free_at = cyc + 1;
    end else begin
      if (p_busy && cyc == p_resp) begin
        e_rdy = 1;
        e_err = p_err;
        if (p_ws == 4'b0 && !p_err) begin
          if (ref_mem.exists(p_idx)) e_rd = ref_mem[p_idx];
          else e_known = 0;
        end
        p_busy = 0;
      end
      if (!p_busy && cyc >= free_at && mem_valid) begin
        p_idx  = int'((mem_addr >> 2) % DEPTH);
        p_wd   = mem_wdata;
        p_ws   = mem_wstrb;
`ifdef MEM_RESPONDER_ERROR_EN
        p_err  = (64'(mem_addr) >= 64'(DEPTH) * 4)
              || (mem_instr && mem_wstrb != 4'b0);
`else
        p_err  = 0;
`endif
        acc_edge = cyc;
        p_commit = cyc + W;
        p_resp   = cyc + 1 + W;
        free_at  = cyc + 2 + W;
        p_busy   = 1;
      end
      if (p_busy && cyc == p_commit && p_ws != 4'b0 && !p_err) begin
        if (ref_mem.exists(p_idx)) begin
          tmp = ref_mem[p_idx];
          for (int b = 0; b < 4; b++)
            if (p_ws[b]) tmp[8*b +: 8] = p_wd[8*b +: 8];
          ref_mem[p_idx] = tmp;
        end else if (p_ws == 4'hF) begin
          ref_mem[p_idx] = p_wd;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("ready", 32'(mem_ready), 32'(e_rdy));
      check("error", 32'(mem_error), 32'(e_err));
      if (e_known) check("rdata", mem_rdata, e_rd);
    end
  end

  task automatic xact(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins, input bit drop,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int  acc;
    bit  got;
    @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wdata = wd;
    mem_wstrb = ws; mem_instr = ins;
    acc = -1; got = 0; rd = '0; er = 0; lat = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      if (acc < 0 && acc_edge == cyc) begin
        acc = cyc;
        if (drop) begin
          mem_valid = 0;
          mem_addr  = $urandom;
          mem_wdata = $urandom;
          mem_wstrb = 4'($urandom);
        end
      end
      if (mem_ready === 1'b1) begin
        got = 1; rd = mem_rdata; er = mem_error; lat = cyc - acc;
      end
    end
    mem_valid = 0;
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout addr=%h got=no_ready exp=ready", a);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
    bit got;
    @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wdata = wd;
    mem_wstrb = ws; mem_instr = 0;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(posedge clk); #1;
      if (acc_edge == cyc) got = 1;
    end
    mem_valid = 0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h got=none exp=accept", a);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;
  int          pool [9] = '{0, 1, 2, 3, 4, 5, 8, 9, 1023};

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          fs [6];
    bit          got;
    logic [5:0]  fexp;
    logic [31:0] a;
    logic [3:0]  ws;
    reset = 1; mem_valid = 0; mem_instr = 0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    f_valid = 0; f_addr = '0; f_wdata = '0; f_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_error", 32'(mem_error), 32'd0);
    check("rst_f_ready", 32'(f_ready), 32'd0);
    reset = 0;

    // Zero-wait responder: write, then two back-to-back reads.
    f_valid = 1; f_addr = 32'h4; f_wdata = 32'h12345678; f_wstrb = 4'hF;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(posedge clk); #1;
      if (f_ready === 1'b1) got = 1;
    end
    f_valid = 0;
    check("fast_wr_ready", 32'(got), 32'd1);
    @(negedge clk);
    f_valid = 1; f_addr = 32'h0; f_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      fs[i] = f_ready;
      if (i == 0) f_addr = 32'h4;
      if (i == 2) f_valid = 0;
      if (i == 3) begin
        check("fast_rd_data", f_rdata, 32'h12345678);
        check("fast_rd_err", 32'(f_error), 32'd0);
      end
    end
    fexp = 6'b001010;
    for (int i = 0; i < 6; i++)
      check($sformatf("fast_pulse%0d", i), 32'(fs[i]), 32'(fexp[i]));

    foreach (pool[i])
      xact(32'(pool[i]) << 2, $urandom, 4'hF, 0, 0, rd, er, lat);

    xact(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
    check("wr10_lat", 32'(lat), 32'd3);
    check("wr10_rdata", rd, 32'd0);
    xact(32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
    check("rd10_lat", 32'(lat), 32'd3);
    check("rd10_rdata", rd, 32'hDEADBEEF);

    xact(32'h20, 32'h11223344, 4'hF, 0, 0, rd, er, lat);
    xact(32'h20, 32'h0000AA00, 4'h2, 0, 0, rd, er, lat);
    xact(32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
    check("rd20_merge", rd, 32'h1122AA44);
    xact(32'h23, 32'h0, 4'h0, 1, 0, rd, er, lat);
    check("rd23_merge", rd, 32'h1122AA44);

    xact(32'h24, 32'h600DCAFE, 4'hF, 0, 1, rd, er, lat);
    check("drop_wr_lat", 32'(lat), 32'd3);
    xact(32'h24, 32'h0, 4'h0, 0, 1, rd, er, lat);
    check("drop_rd_lat", 32'(lat), 32'd3);
    check("drop_rd_data", rd, 32'h600DCAFE);

    xact(32'h8, 32'h55AA55AA, 4'hF, 0, 0, rd, er, lat);
    start_req(32'h8, 32'hCAFEF00D, 4'hF);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); reset = (i == 0);
      @(posedge clk); #1; pulses += int'(mem_ready);
    end
    reset = 0;
    check("rst_wait_pulses", 32'(pulses), 32'd0);
    xact(32'h8, 32'h0, 4'h0, 0, 0, rd, er, lat);
    check("rst_wait_old", rd, 32'h55AA55AA);

    @(negedge clk);
    reset = 1; mem_valid = 1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    @(negedge clk);
    reset = 0; mem_valid = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; pulses += int'(mem_ready);
    end
    check("valid_in_reset", 32'(pulses), 32'd0);

    xact(32'h0, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lat);
    xact(32'h4, 32'h44444444, 4'hF, 0, 0, rd, er, lat);
    xact(32'h1000, 32'h0, 4'h0, 0, 0, rd, er, lat);
    check("oor_lat", 32'(lat), 32'd3);
`ifdef MEM_RESPONDER_ERROR_EN
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
`else
    check("oor_err", 32'(er), 32'd0);
    check("oor_rdata", rd, 32'h0BADF00D);
`endif
    xact(32'h4, 32'h99999999, 4'hF, 1, 0, rd, er, lat);
    xact(32'h4, 32'h0, 4'h0, 0, 0, rd, er, lat);
`ifdef MEM_RESPONDER_ERROR_EN
    check("iwr_data", rd, 32'h44444444);
`else
    check("iwr_data", rd, 32'h99999999);
`endif

    for (int it = 0; it < 300; it++) begin
      a = (32'(pool[$urandom_range(0, 8)]) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin
        start_req(a, $urandom, ws);
        repeat ($urandom_range(0, W + 1)) @(negedge clk);
        @(negedge clk); reset = 1; mem_valid = 1;
        @(negedge clk); reset = 0; mem_valid = 0;
      end else begin
        xact(a, $urandom, ws, 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 2) == 0, rd, er, lat);
        check("rnd_lat", 32'(lat), 32'(W + 1));
      end
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words of backing storage (power of two, at least 4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra cycles inserted between request acceptance and response (0 to 15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port mem_valid, input, 1, meaning the initiator presents a request.
REQ-006 The block SHALL have port mem_instr, input, 1, meaning the request is an instruction fetch.
REQ-007 The block SHALL have port mem_addr, input, 32, meaning the byte address.
REQ-008 The block SHALL have port mem_wdata, input, 32, meaning the write data.
REQ-009 The block SHALL have port mem_wstrb, input, 4, meaning byte write enables; 0 means read.
REQ-010 The block SHALL have port mem_ready, output, 1, meaning a one-cycle response strobe.
REQ-011 The block SHALL have port mem_rdata, output, 32, meaning the read data, valid while mem_ready=1.
REQ-012 The block SHALL have port mem_error, output, 1, meaning the access was rejected, valid while mem_ready=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, mem_valid=1 SHALL latch mem_addr, mem_wdata, mem_wstrb and mem_instr, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 In WAIT, a down-counter loaded with WAIT_CYCLES SHALL decrement each cycle, moving to RESP on the edge where it reaches 0.
REQ-016 For a request sampled at edge t, mem_ready SHALL be high for exactly the one cycle following edge t+1+WAIT_CYCLES; RESP SHALL then return to IDLE.
REQ-017 mem_ready SHALL never be high for two consecutive cycles; the earliest next acceptance is the edge ending the RESP cycle (IDLE evaluated the following cycle).
REQ-018 Inputs SHALL be ignored outside IDLE; if mem_valid drops mid-request, the latched request still completes and mem_ready still pulses.
REQ-019 The word index SHALL be latched mem_addr[log2(DEPTH)+1:2]; mem_addr[1:0] SHALL be ignored.
REQ-020 A write SHALL update only the bytes whose mem_wstrb bit is set, on the edge entering RESP; mem_rdata SHALL be 0 during a write response.
REQ-021 A read SHALL return the full stored word on mem_rdata during RESP, including any write committed in an earlier response.
REQ-022 mem_rdata SHALL be 0 whenever mem_ready=0.
REQ-023 mem_instr SHALL have no effect on timing.

Reset
REQ-024 When reset=1 at an edge, the block SHALL go to IDLE with mem_ready=0, mem_rdata=0, mem_error=0 and counter=0.
REQ-025 Reset during WAIT or RESP SHALL discard the request with no mem_ready pulse, and a pending write SHALL NOT commit.
REQ-026 Reset SHALL NOT clear storage contents.
REQ-027 mem_valid sampled in the same cycle as reset=1 SHALL NOT be accepted.

Configuration
REQ-028 The block SHALL support macro MEM_RESPONDER_ERROR_EN.
REQ-029 With MEM_RESPONDER_ERROR_EN defined, an access SHALL be an error if mem_addr >= DEPTH*4 or if mem_instr=1 with mem_wstrb!=0; timing SHALL be unchanged.
REQ-030 With MEM_RESPONDER_ERROR_EN defined, an error access SHALL write nothing, set mem_rdata=0, and set mem_error=1 for the mem_ready cycle.
REQ-031 Without MEM_RESPONDER_ERROR_EN, mem_error SHALL be tied to 0, addresses SHALL wrap modulo DEPTH*4, and instruction-flagged writes SHALL commit normally.

Verification
REQ-032 Bench scenario: WAIT_CYCLES=2; write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF at edge t -> mem_ready high in cycle after edge t+3, mem_rdata 0; then read 0x10 -> mem_rdata 0xDEADBEEF.
REQ-033 Bench scenario: word 0x20 holds 0x11223344; write wstrb 0x2, wdata 0x0000AA00 -> read 0x20 returns 0x1122AA44; read 0x23 returns the same word.
REQ-034 Bench scenario: WAIT_CYCLES=0 with back-to-back reads of 0x0 and 0x4 -> mem_ready pulses are 1 cycle wide and separated by 1 low cycle.
REQ-035 Bench scenario: reset asserted during WAIT of a write of 0xCAFEF00D to 0x8 -> no mem_ready pulse; a later read of 0x8 returns the old value.
REQ-036 Bench scenario: with MEM_RESPONDER_ERROR_EN defined and DEPTH=1024, read 0x1000 -> mem_error=1, mem_rdata=0; without the macro, the same read returns the word at 0x0 with mem_error=0.
REQ-037 Bench scenario: mem_valid dropped one cycle after acceptance -> mem_ready still pulses once at the nominal cycle.
